accum_core_param: RTL and testbench

ACCUM_CORE_PARAM -- requirements
Module: accum_core_param

---
 rtl/accum_core_param.sv | 156 +++++++++++++++
 tb/tb_accum_core_param.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/accum_core_param.sv
// rtl/accum_core_param.sv - accumulator CPU core with program-load port and handshaked I/O
// Fetch/decode/exec FSM over a single-port word memory; memory survives reset.
module accum_core_param #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 8
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              start,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [WIDTH-1:0]  prog_data,
  input  logic [WIDTH-1:0]  Inputio,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [WIDTH-1:0]  Outputio,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        Opcode,
  output logic [ADDR_W-1:0] PCOut,
  output logic              Overflow,
  output logic              Halted
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [3:0] OP_HLT = 4'h0, OP_LDI = 4'h1, OP_LD  = 4'h2, OP_ST  = 4'h3,
                         OP_ADD = 4'h4, OP_SUB = 4'h5, OP_AND = 4'h6, OP_OR  = 4'h7,
                         OP_JMP = 4'h8, OP_BEQZ = 4'h9, OP_BNEZ = 4'hA, OP_IN = 4'hB,
                         OP_OUT = 4'hC;

  typedef enum logic [2:0] {
    S_HALT, S_FETCH, S_DECODE, S_EXEC, S_WAIT_IN, S_WAIT_OUT
  } state_t;

  state_t state, next_state;

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] pc;
  logic [WIDTH-1:0]  acc;
  logic [WIDTH-1:0]  mdr;
  logic [3:0]        ir_op;
  logic [ADDR_W-1:0] ir_arg;

  // Only the opcode and operand fields of IR are kept; middle bits carry no meaning.
  logic [WIDTH-1:0] fetch_word;
  logic [WIDTH-1:0] sum, diff;
  logic             add_ovf, sub_ovf;

  assign fetch_word = mem[pc];
  assign sum        = acc + mdr;
  assign diff       = acc - mdr;
  assign add_ovf    = (acc[WIDTH-1] == mdr[WIDTH-1]) && (sum[WIDTH-1] != acc[WIDTH-1]);
  assign sub_ovf    = (acc[WIDTH-1] != mdr[WIDTH-1]) && (diff[WIDTH-1] != acc[WIDTH-1]);

  always_ff @(posedge CLK) begin
    if (Reset) state <= S_HALT;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_HALT:   if (start) next_state = S_FETCH;
      S_FETCH:  next_state = S_DECODE;
      S_DECODE: begin
        case (ir_op)
          OP_HLT:                                 next_state = S_HALT;
          OP_LD, OP_ADD, OP_SUB, OP_AND, OP_OR:   next_state = S_EXEC;
          OP_IN:                                  next_state = S_WAIT_IN;
          OP_OUT:                                 next_state = S_WAIT_OUT;
          default:                                next_state = S_FETCH;
        endcase
      end
      S_EXEC:     next_state = S_FETCH;
      S_WAIT_IN:  if (in_valid)  next_state = S_FETCH;
      S_WAIT_OUT: if (out_ready) next_state = S_FETCH;
      default:    next_state = S_HALT;
    endcase
  end

  always_comb begin
    in_ready  = (state == S_WAIT_IN);
    out_valid = (state == S_WAIT_OUT);
    Halted    = (state == S_HALT);
  end

  assign Opcode = ir_op;
  assign PCOut  = pc;

  // Memory has no reset so a program survives a reset; reset still blocks writes.
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      if (state == S_HALT && prog_we)
        mem[prog_addr] <= prog_data;
      else if (state == S_DECODE && ir_op == OP_ST)
        mem[ir_arg] <= acc;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      pc       <= '0;
      acc      <= '0;
      mdr      <= '0;
      ir_op    <= '0;
      ir_arg   <= '0;
      Outputio <= '0;
      Overflow <= 1'b0;
    end else begin
      case (state)
        S_HALT: begin
          if (start) begin
            pc       <= '0;
            Overflow <= 1'b0;
          end
        end
        S_FETCH: begin
          ir_op  <= fetch_word[WIDTH-1:WIDTH-4];
          ir_arg <= fetch_word[ADDR_W-1:0];
          pc     <= pc + ADDR_W'(1);
        end
        S_DECODE: begin
          case (ir_op)
            OP_LDI:                               acc      <= WIDTH'(ir_arg);
            OP_LD, OP_ADD, OP_SUB, OP_AND, OP_OR: mdr      <= mem[ir_arg];
            OP_JMP:                               pc       <= ir_arg;
            OP_BEQZ: if (acc == '0)               pc       <= ir_arg;
            OP_BNEZ: if (acc != '0)               pc       <= ir_arg;
            OP_OUT:                               Outputio <= acc;
            default: ;
          endcase
        end
        S_EXEC: begin
          case (ir_op)
            OP_LD:  acc <= mdr;
            OP_ADD: begin
              acc <= sum;
              if (add_ovf) Overflow <= 1'b1;
            end
            OP_SUB: begin
              acc <= diff;
              if (sub_ovf) Overflow <= 1'b1;
            end
            OP_AND: acc <= acc & mdr;
            OP_OR:  acc <= acc | mdr;
            default: ;
          endcase
        end
        S_WAIT_IN: if (in_valid) acc <= Inputio;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_accum_core_param.sv
// tb/tb_accum_core_param.sv - directed self-checking bench for accum_core_param
module tb_accum_core_param;

  logic        clk = 1'b0;
  logic        Reset, start, prog_we, in_valid, out_ready;
  logic [7:0]  prog_addr;
  logic [15:0] prog_data, Inputio;
  logic        in_ready, out_valid, Overflow, Halted;
  logic [15:0] Outputio;
  logic [3:0]  Opcode;
  logic [7:0]  PCOut;

  int checks = 0;
  int errors = 0;
  int in_hi, out_hi, out_extra;
  logic out_stable;

  accum_core_param #(.WIDTH(16), .ADDR_W(8)) dut (
    .CLK(clk), .Reset(Reset), .start(start), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data), .Inputio(Inputio),
    .in_valid(in_valid), .in_ready(in_ready), .Outputio(Outputio),
    .out_valid(out_valid), .out_ready(out_ready), .Opcode(Opcode),
    .PCOut(PCOut), .Overflow(Overflow), .Halted(Halted)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic prog(input logic [7:0] a, input logic [15:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    step();
    prog_we = 1'b0;
  endtask

  task automatic go();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_halted(input string tag);
    for (int i = 0; i < 100 && !Halted; i++) step();
    chk(tag, Halted, 1);
  endtask

  initial begin
    Reset = 1'b1; start = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    Inputio = '0; in_valid = 1'b0; out_ready = 1'b0;
    step(); step();
    chk("rst_halted", Halted, 1);
    chk("rst_pc", PCOut, 0);
    chk("rst_opcode", Opcode, 0);
    chk("rst_outputio", Outputio, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_overflow", Overflow, 0);
    Reset = 1'b0;

    // LDI 0x7F; ADD M16 (0x7FFF) -> signed overflow
    prog(8'h00, 16'h107F); prog(8'h01, 16'h4010); prog(8'h02, 16'h0000); prog(8'h10, 16'h7FFF);
    go();
    chk("t1_running", Halted, 0);
    wait_halted("t1_halt");
    chk("t1_acc", dut.acc, 16'h807E);
    chk("t1_overflow", Overflow, 1);
    chk("t1_pc", PCOut, 3);

    // IN then OUT with stalled handshakes
    prog(8'h00, 16'hB000); prog(8'h01, 16'hC000); prog(8'h02, 16'h0000);
    go();
    chk("t2_ovf_cleared", Overflow, 0);
    for (int i = 0; i < 20 && !in_ready; i++) step();
    chk("t2_wait_in", in_ready, 1);
    in_hi = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin Inputio = 16'h1234; in_valid = 1'b1; end
      if (in_ready) in_hi++;
      step();
    end
    in_valid = 1'b0;
    chk("t2_in_ready_cycles", in_hi, 4);
    chk("t2_in_ready_low", in_ready, 0);
    for (int i = 0; i < 20 && !out_valid; i++) step();
    chk("t2_wait_out", out_valid, 1);
    out_hi = 0; out_stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) out_ready = 1'b1;
      if (out_valid) out_hi++;
      if (Outputio !== 16'h1234) out_stable = 1'b0;
      step();
    end
    out_ready = 1'b0;
    chk("t2_out_valid_cycles", out_hi, 5);
    chk("t2_out_stable", out_stable, 1);
    out_extra = 0;
    for (int i = 0; i < 20 && !Halted; i++) begin
      if (out_valid) out_extra++;
      step();
    end
    chk("t2_halt", Halted, 1);
    chk("t2_single_transfer", out_extra, 0);
    chk("t2_out_hold", Outputio, 16'h1234);

    // BEQZ taken, BNEZ not taken
    prog(8'h00, 16'h1000); prog(8'h01, 16'h9005); prog(8'h05, 16'hA000); prog(8'h06, 16'h0000);
    go();
    wait_halted("t3_halt");
    chk("t3_pc", PCOut, 7);

    // ST then LD of same address, SUB overflow, AND, OR
    prog(8'h00, 16'h1005); prog(8'h01, 16'h3020); prog(8'h02, 16'h2020); prog(8'h03, 16'h5021);
    prog(8'h04, 16'h6022); prog(8'h05, 16'h7023); prog(8'h06, 16'h0000);
    prog(8'h20, 16'hFFFF); prog(8'h21, 16'h8000); prog(8'h22, 16'h00FF); prog(8'h23, 16'h0F00);
    go();
    wait_halted("t4_halt");
    chk("t4_acc", dut.acc, 16'h0F05);
    chk("t4_overflow", Overflow, 1);
    chk("t4_st_mem", dut.mem[32], 16'h0005);
    chk("t4_pc", PCOut, 7);

    // PC wrap at 255, program port ignored while running
    prog(8'h00, 16'h80FF); prog(8'hFF, 16'h8003); prog(8'h03, 16'h0000);
    go();
    prog_we = 1'b1; prog_addr = 8'h03; prog_data = 16'h1001;
    for (int i = 0; i < 20 && !(Opcode == 4'h8 && PCOut == 8'h00); i++) step();
    chk("t5_wrap_pc", PCOut, 0);
    chk("t5_wrap_op", Opcode, 8);
    step();
    chk("t5_jmp_pc", PCOut, 3);
    wait_halted("t5_halt");
    prog_we = 1'b0;
    chk("t5_final_pc", PCOut, 4);
    chk("t5_mem_unchanged", dut.mem[3], 16'h0000);

    // Reset while waiting on output, then rerun
    prog(8'h00, 16'h1055); prog(8'h01, 16'hC000); prog(8'h02, 16'h0000);
    go();
    for (int i = 0; i < 20 && !out_valid; i++) step();
    chk("t6_out_valid", out_valid, 1);
    chk("t6_outputio", Outputio, 16'h0055);
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    chk("t6_rst_out_valid", out_valid, 0);
    chk("t6_rst_halted", Halted, 1);
    chk("t6_rst_outputio", Outputio, 0);
    chk("t6_rst_pc", PCOut, 0);
    go();
    for (int i = 0; i < 20 && !out_valid; i++) step();
    chk("t6_rerun_out_valid", out_valid, 1);
    chk("t6_rerun_outputio", Outputio, 16'h0055);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    wait_halted("t6_rerun_halt");

    // Reset beats start and prog_we in the same cycle
    Reset = 1'b1; start = 1'b1; prog_we = 1'b1; prog_addr = 8'h00; prog_data = 16'h1077;
    step();
    Reset = 1'b0; start = 1'b0; prog_we = 1'b0;
    chk("t7_rst_prio_halted", Halted, 1);
    chk("t7_rst_prio_mem", dut.mem[0], 16'h1055);

    // start and prog_we together: HLT written to M0 is executed
    start = 1'b1; prog_we = 1'b1; prog_addr = 8'h00; prog_data = 16'h0000;
    step();
    start = 1'b0; prog_we = 1'b0;
    chk("t8_fetch", Halted, 0);
    step();
    chk("t8_decode", Halted, 0);
    step();
    chk("t8_halted", Halted, 1);
    chk("t8_pc", PCOut, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
